// File: rtl/freq_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : freq_meter_pkg
// Purpose  : Shared types and defaults for the digital frequency meter.
//            Holds the one-hot gate FSM state type and the default gate
//            length / result width that the transmit stage also relies on.
// Revision : 1.0 - initial release
// ============================================================================
package freq_meter_pkg;

    // One-hot encoding keeps the state decode to a single bit per state.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        ARM  = 3'b010,
        GATE = 3'b100
    } gate_state_t;

    // 1 s gate at a 1 MHz system clock.
    localparam int c_DEFAULT_GATE_CYCLES = 1_000_000;
    localparam int c_DEFAULT_CNT_W       = 32;

endpackage : freq_meter_pkg
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_detect
// Purpose  : Brings an asynchronous input into the clk domain through a
//            SYNC_STAGES flop chain and emits a one-cycle pulse for each
//            rising edge of the synchronized level.
// Ports    : clk        - system clock
//            rst        - synchronous, active-high reset
//            async_in   - asynchronous input level
//            rise_pulse - high for one cycle per synchronized rising edge
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            // r_sync[0] is the metastability-exposed flop; only the last
            // stage is used by downstream logic.
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign rise_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule : sync_edge_detect
`default_nettype wire

// File: rtl/freq_gate_counter.sv
`default_nettype none
// ============================================================================
// Module   : freq_gate_counter
// Purpose  : Gate-time frequency measurement. On start, counts rising edges
//            of the asynchronous sig_in over exactly GATE_CYCLES clocks
//            (after one ARM cycle) and publishes the count.
// Ports    : clk, rst     - system clock, synchronous active-high reset
//            start        - level request, sampled only in IDLE
//            busy         - high while a measurement is in progress
//            sig_in       - measured signal (asynchronous)
//            count        - edge count of last completed gate
//            count_valid  - one-cycle pulse when count updates
//            overflow     - accumulator overflowed during last gate
// Config   : FREQ_GATE_COUNTER_SATURATE_EN - when defined the accumulator
//            saturates at all-ones on overflow; otherwise it wraps.
// Revision : 1.0 - initial release
// ============================================================================
module freq_gate_counter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = c_DEFAULT_GATE_CYCLES,
    parameter int CNT_W       = c_DEFAULT_CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    input  logic             sig_in,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             overflow
);

    localparam int               c_GC_W    = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [c_GC_W-1:0] c_GC_LAST = c_GC_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_ACC_MAX = '1;

    gate_state_t       r_state;
    logic              r_busy;
    logic [CNT_W-1:0]  r_count;
    logic              r_count_valid;
    logic              r_overflow;
    logic [CNT_W-1:0]  r_acc;
    logic              r_ovf_acc;
    logic [c_GC_W-1:0] r_gate_cnt;

    logic              w_edge;
    logic              w_wrap;
    logic [CNT_W-1:0]  w_acc_next;
    logic              w_ovf_next;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst        (rst),
        .async_in   (sig_in),
        .rise_pulse (w_edge)
    );

    // Next accumulator value for a GATE cycle, including this cycle's edge.
    always_comb begin
        w_wrap = w_edge & (r_acc == c_ACC_MAX);
`ifdef FREQ_GATE_COUNTER_SATURATE_EN
        w_acc_next = w_wrap ? r_acc : (r_acc + {{(CNT_W-1){1'b0}}, w_edge});
`else
        w_acc_next = r_acc + {{(CNT_W-1){1'b0}}, w_edge};
`endif
        w_ovf_next = r_ovf_acc | w_wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_count       <= '0;
            r_count_valid <= 1'b0;
            r_overflow    <= 1'b0;
            r_acc         <= '0;
            r_ovf_acc     <= 1'b0;
            r_gate_cnt    <= '0;
        end else begin
            r_count_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= ARM;
                        r_busy  <= 1'b1;
                    end
                end
                ARM: begin
                    // Edge seen here predates the gate and is dropped.
                    r_acc      <= '0;
                    r_ovf_acc  <= 1'b0;
                    r_gate_cnt <= '0;
                    r_state    <= GATE;
                end
                GATE: begin
                    r_acc      <= w_acc_next;
                    r_ovf_acc  <= w_ovf_next;
                    r_gate_cnt <= r_gate_cnt + 1'b1;
                    if (r_gate_cnt == c_GC_LAST) begin
                        // Result and busy change together so a controller
                        // seeing busy=0 always reads the fresh count.
                        r_count       <= w_acc_next;
                        r_overflow    <= w_ovf_next;
                        r_count_valid <= 1'b1;
                        r_state       <= IDLE;
                        r_busy        <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign count       = r_count;
    assign count_valid = r_count_valid;
    assign overflow    = r_overflow;

endmodule : freq_gate_counter
`default_nettype wire

// File: tb/tb_freq_gate_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_gate_counter
// Purpose  : Self-checking bench for freq_gate_counter. A wide instance
//            (CNT_W=32) covers timing, handshake, abort and back-to-back
//            runs; a narrow instance (CNT_W=4) covers accumulator overflow.
//            Expected counts come from the gate length divided by the
//            stimulus period.
// Revision : 1.0 - initial release
// ============================================================================
module tb_freq_gate_counter;

    localparam int c_GATE = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        sig_in;
    logic        start_a, start_b;
    logic        busy_a, busy_b;
    logic [31:0] count_a;
    logic [3:0]  count_b;
    logic        valid_a, valid_b;
    logic        ovf_a, ovf_b;

    int checks = 0;
    int errors = 0;

    // Stimulus generator state: periodic square wave or forced level.
    int period    = 10;
    int phase     = 0;
    bit sig_force = 1'b0;
    bit sig_level = 1'b0;
    int valid_pulses_a = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sig_force) begin
            sig_in = sig_level;
        end else begin
            phase  = (phase + 1) % period;
            sig_in = (phase < period / 2);
        end
        if (valid_a) valid_pulses_a++;
    end

    freq_gate_counter #(.GATE_CYCLES(c_GATE), .CNT_W(32), .SYNC_STAGES(2)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .sig_in(sig_in),
        .count(count_a), .count_valid(valid_a), .overflow(ovf_a)
    );

    freq_gate_counter #(.GATE_CYCLES(c_GATE), .CNT_W(4), .SYNC_STAGES(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .sig_in(sig_in),
        .count(count_b), .count_valid(valid_b), .overflow(ovf_b)
    );

    // One measurement on instance A. Call at a negedge. hold keeps start high
    // throughout (back-to-back mode); poke>0 pulses start at that busy cycle.
    task automatic run_a(input int exp, input bit hold, input int poke, input string name);
        int t;
        int n;
        bit early_valid;
        start_a = 1'b1;
        t = 0;
        while (!busy_a && t < 10) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!busy_a) begin
            errors++;
            $display("FAIL %s start_ack: busy=%0b required 1", name, busy_a);
            start_a = 1'b0;
            return;
        end
        if (!hold) start_a = 1'b0;
        n = 0;
        early_valid = 1'b0;
        while (busy_a && n < 300) begin
            n++;
            if (valid_a) early_valid = 1'b1;
            if (poke > 0 && n == poke) start_a = 1'b1;
            if (poke > 0 && n == poke + 1 && !hold) start_a = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (n !== c_GATE + 1) begin
            errors++;
            $display("FAIL %s busy_len: got %0d required %0d", name, n, c_GATE + 1);
        end
        checks++;
        if (early_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s valid_while_busy: got 1 required 0", name);
        end
        checks++;
        if (valid_a !== 1'b1) begin
            errors++;
            $display("FAIL %s valid_at_done: got %0b required 1", name, valid_a);
        end
        checks++;
        if (count_a !== exp) begin
            errors++;
            $display("FAIL %s count: got %0d required %0d", name, count_a, exp);
        end
        checks++;
        if (ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL %s overflow: got %0b required 0", name, ovf_a);
        end
        @(negedge clk);
        checks++;
        if (valid_a !== 1'b0) begin
            errors++;
            $display("FAIL %s valid_width: got %0b required 0", name, valid_a);
        end
        if (hold) begin
            checks++;
            if (busy_a !== 1'b1) begin
                errors++;
                $display("FAIL %s idle_gap: busy=%0b required 1 after one idle cycle", name, busy_a);
            end
        end
    endtask

    task automatic set_period(input int p);
        @(posedge clk);
        sig_force = 1'b0;
        period    = p;
        phase     = $urandom_range(p - 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_a, valid_a, ovf_a, count_a} !== 35'd0) begin
            errors++;
            $display("FAIL reset_a: busy=%0b valid=%0b ovf=%0b count=%0d required all 0",
                     busy_a, valid_a, ovf_a, count_a);
        end
        checks++;
        if ({busy_b, valid_b, ovf_b, count_b} !== 7'd0) begin
            errors++;
            $display("FAIL reset_b: busy=%0b valid=%0b ovf=%0b count=%0d required all 0",
                     busy_b, valid_b, ovf_b, count_b);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        set_period(10);
        run_a(c_GATE / 10, 1'b0, 0, "basic");
        repeat (2) @(negedge clk);
    endtask

    task automatic test_constant();
        @(posedge clk);
        sig_force = 1'b1;
        sig_level = 1'b0;
        repeat (5) @(negedge clk);
        run_a(0, 1'b0, 0, "const_low");
        @(posedge clk);
        sig_level = 1'b1;
        @(negedge clk);
        @(negedge clk);
        // Synchronized rise lands on the ARM cycle and must not be counted.
        run_a(0, 1'b0, 0, "const_high");
        repeat (2) @(negedge clk);
    endtask

    task automatic test_overflow();
        int t;
        int exp;
`ifdef FREQ_GATE_COUNTER_SATURATE_EN
        exp = 15;
`else
        exp = (c_GATE / 2) % 16;
`endif
        set_period(2);
        start_b = 1'b1;
        t = 0;
        while (!busy_b && t < 10) begin
            @(negedge clk);
            t++;
        end
        start_b = 1'b0;
        t = 0;
        while (busy_b && t < 300) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (busy_b !== 1'b0) begin
            errors++;
            $display("FAIL ovf_timeout: busy=%0b required 0", busy_b);
        end
        checks++;
        if (count_b !== exp[3:0]) begin
            errors++;
            $display("FAIL ovf_count: got %0d required %0d", count_b, exp);
        end
        checks++;
        if (ovf_b !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: got %0b required 1", ovf_b);
        end
        checks++;
        if (valid_b !== 1'b1) begin
            errors++;
            $display("FAIL ovf_valid: got %0b required 1", valid_b);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_start_mid_gate();
        set_period(10);
        run_a(c_GATE / 10, 1'b0, 50, "mid_start");
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort();
        int n;
        int pulses_before;
        set_period(10);
        start_a = 1'b1;
        n = 0;
        while (!busy_a && n < 10) begin
            @(negedge clk);
            n++;
        end
        start_a = 1'b0;
        pulses_before = valid_pulses_a;
        // First busy negedge is ARM; gate_cnt reaches 40 at the 42nd.
        for (int i = 1; i < 42; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy_a, valid_a, ovf_a, count_a} !== 35'd0) begin
            errors++;
            $display("FAIL abort_outputs: busy=%0b valid=%0b ovf=%0b count=%0d required all 0",
                     busy_a, valid_a, ovf_a, count_a);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (valid_pulses_a !== pulses_before) begin
            errors++;
            $display("FAIL abort_no_valid: pulses=%0d required %0d", valid_pulses_a, pulses_before);
        end
        run_a(c_GATE / 10, 1'b0, 0, "after_abort");
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        set_period(10);
        for (int r = 0; r < 3; r++) run_a(c_GATE / 10, 1'b1, 0, "b2b");
        start_a = 1'b0;
        // Let the in-flight run drain.
        repeat (c_GATE + 5) @(negedge clk);
    endtask

    task automatic test_random();
        int periods[8] = '{2, 4, 5, 10, 20, 25, 50, 100};
        int p;
        for (int r = 0; r < 6; r++) begin
            p = periods[$urandom_range(7)];
            set_period(p);
            run_a(c_GATE / p, 1'b0, 0, $sformatf("rand_p%0d", p));
            repeat ($urandom_range(4)) @(negedge clk);
        end
    endtask

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        sig_in  = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_constant();
        test_overflow();
        test_start_mid_gate();
        test_abort();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_freq_gate_counter
`default_nettype wire
